// File: rtl/nes_video_timing.sv
// Pixel-enable divider, PPU-following raster with free-running fallback, and registered
// sync/blank/DE/colour outputs for the NES video path.
module nes_video_timing #(
  parameter int unsigned CLK_DIV      = 8,
  parameter int unsigned H_TOTAL      = 341,
  parameter int unsigned H_ACTIVE     = 256,
  parameter int unsigned V_TOTAL_NTSC = 262,
  parameter int unsigned V_TOTAL_PAL  = 312,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned HS_START     = 277,
  parameter int unsigned HS_END       = 318,
  parameter int unsigned VS_START     = 245,
  parameter int unsigned VS_END       = 254,
  parameter int unsigned OS_LEFT      = 10,
  parameter int unsigned OS_RIGHT     = 8,
  parameter int unsigned OS_TOP       = 6,
  parameter int unsigned OS_BOTTOM    = 10,
  parameter int unsigned SYNC_LINE    = 511,
  parameter int unsigned LOCK_FRAMES  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] color,
  input  logic [8:0] count_h,
  input  logic [8:0] count_v,
  input  logic       pal_mode,
  input  logic       hide_overscan,
  output logic       ce_pix,
  output logic       ce_pix_n,
  output logic       free_run,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic [5:0] color_out,
  output logic       frame_start
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

  localparam logic [9:0] HTotM1   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VNtscM1  = 10'(V_TOTAL_NTSC - 1);
  localparam logic [9:0] VPalM1   = 10'(V_TOTAL_PAL - 1);
  localparam logic [9:0] HAct     = 10'(H_ACTIVE);
  localparam logic [9:0] VAct     = 10'(V_ACTIVE);
  localparam logic [9:0] HCropR   = 10'(H_ACTIVE - OS_RIGHT);
  localparam logic [9:0] HCropL   = 10'(OS_LEFT);
  localparam logic [9:0] VCropB   = 10'(V_ACTIVE - OS_BOTTOM);
  localparam logic [9:0] VCropT   = 10'(OS_TOP);
  localparam logic [9:0] HsStart  = 10'(HS_START);
  localparam logic [9:0] HsEnd    = 10'(HS_END);
  localparam logic [9:0] VsStart  = 10'(VS_START);
  localparam logic [9:0] VsEnd    = 10'(VS_END);
  localparam logic [8:0] SyncLine = 9'(SYNC_LINE);
  localparam logic [2:0] LockMax  = 3'(LOCK_FRAMES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ce_pix_q, ce_pix_d;
  logic            ce_pix_n_q, ce_pix_n_d;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [2:0] free_cnt_q, free_cnt_d;
  logic [8:0] prev_v_q, prev_v_d;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       de_q, de_d;
  logic [5:0] color_q, color_d;
  logic       frame_start_q, frame_start_d;

  logic       resync;
  logic [9:0] vtot_m1;
  logic [9:0] hc, vc;

  // Divider: enables are registered so they are one clk wide and glitch free.
  always_comb begin
    cnt_d      = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    ce_pix_d   = (cnt_q == CntLast);
    ce_pix_n_d = (cnt_q == CntHalf);
  end

  assign resync  = (prev_v_q == SyncLine) && (count_v == 9'd0);
  assign vtot_m1 = pal_mode ? VPalM1 : VNtscM1;

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    free_cnt_d = free_cnt_q;
    prev_v_d   = prev_v_q;
    if (ce_pix_n_q) begin
      prev_v_d = count_v;
      if (resync) begin
        h_d        = '0;
        v_d        = '0;
        free_cnt_d = '0;
      end else if (h_q >= HTotM1) begin
        h_d = '0;
        // >= rather than == so a late PAL->NTSC switch still wraps at the end of this line.
        if (v_q >= vtot_m1) begin
          v_d = '0;
          if (free_cnt_q != LockMax) free_cnt_d = free_cnt_q + 3'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign free_run = (free_cnt_q == LockMax);
  assign hc       = free_run ? h_q : {1'b0, count_h};
  assign vc       = free_run ? v_q : {1'b0, count_v};

  always_comb begin
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    color_d       = color_q;
    frame_start_d = frame_start_q;
    if (ce_pix_q) begin
      if (hide_overscan) begin
        hblank_d = (hc > HCropR) || (hc < HCropL);
        vblank_d = (vc > VCropB) || (vc < VCropT);
      end else begin
        hblank_d = (hc >= HAct);
        vblank_d = (vc >= VAct);
      end
      hsync_d       = (hc >= HsStart) && (hc < HsEnd);
      vsync_d       = (vc >= VsStart) && (vc < VsEnd);
      de_d          = !(hblank_d || vblank_d);
      color_d       = de_d ? color : 6'd0;
      frame_start_d = (hc == 10'd0) && (vc == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      ce_pix_q      <= 1'b0;
      ce_pix_n_q    <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      free_cnt_q    <= '0;
      prev_v_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b0;
      color_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      ce_pix_q      <= ce_pix_d;
      ce_pix_n_q    <= ce_pix_n_d;
      h_q           <= h_d;
      v_q           <= v_d;
      free_cnt_q    <= free_cnt_d;
      prev_v_q      <= prev_v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      color_q       <= color_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ce_pix      = ce_pix_q;
  assign ce_pix_n    = ce_pix_n_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign color_out   = color_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_nes_video_timing.sv
// Directed bench: full-size instance for divider/PPU/overscan, a shrunken raster instance
// for free-run, resync, PAL and reset behaviour.
module tb_nes_video_timing;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] color = 6'd0;
  logic [8:0] count_h = 9'd0;
  logic [8:0] count_v = 9'd0;
  logic       pal_mode = 1'b0;
  logic       hide_overscan = 1'b0;

  logic       b_ce_pix, b_ce_pix_n, b_free_run, b_hsync, b_vsync, b_hblank, b_vblank, b_de;
  logic       b_frame_start;
  logic [5:0] b_color_out;
  logic       s_ce_pix, s_ce_pix_n, s_free_run, s_hsync, s_vsync, s_hblank, s_vblank, s_de;
  logic       s_frame_start;
  logic [5:0] s_color_out;

  logic [6:0] b_flags, s_flags;
  assign b_flags = {b_hsync, b_vsync, b_hblank, b_vblank, b_de, b_frame_start, b_free_run};
  assign s_flags = {s_hsync, s_vsync, s_hblank, s_vblank, s_de, s_frame_start, s_free_run};

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  nes_video_timing dut_b (
    .clk(clk), .reset_n(reset_n), .color(color), .count_h(count_h), .count_v(count_v),
    .pal_mode(pal_mode), .hide_overscan(hide_overscan), .ce_pix(b_ce_pix),
    .ce_pix_n(b_ce_pix_n), .free_run(b_free_run), .hsync(b_hsync), .vsync(b_vsync),
    .hblank(b_hblank), .vblank(b_vblank), .de(b_de), .color_out(b_color_out),
    .frame_start(b_frame_start)
  );

  // Small raster: 20 px x 10/14 lines, hsync px 14..16, vsync lines 7..8.
  nes_video_timing #(
    .CLK_DIV(8), .H_TOTAL(20), .H_ACTIVE(12), .V_TOTAL_NTSC(10), .V_TOTAL_PAL(14),
    .V_ACTIVE(6), .HS_START(14), .HS_END(17), .VS_START(7), .VS_END(9), .OS_LEFT(1),
    .OS_RIGHT(1), .OS_TOP(1), .OS_BOTTOM(1), .SYNC_LINE(511), .LOCK_FRAMES(3)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .color(color), .count_h(count_h), .count_v(count_v),
    .pal_mode(pal_mode), .hide_overscan(hide_overscan), .ce_pix(s_ce_pix),
    .ce_pix_n(s_ce_pix_n), .free_run(s_free_run), .hsync(s_hsync), .vsync(s_vsync),
    .hblank(s_hblank), .vblank(s_vblank), .de(s_de), .color_out(s_color_out),
    .frame_start(s_frame_start)
  );

  // {h, v, hsync vsync hblank vblank de frame_start free_run}, hide_overscan=0
  logic [24:0] ppu_tbl [14] = '{
    {9'd0,   9'd0,   7'b0000110}, {9'd255, 9'd10,  7'b0000100},
    {9'd256, 9'd10,  7'b0010000}, {9'd276, 9'd10,  7'b0010000},
    {9'd277, 9'd10,  7'b1010000}, {9'd317, 9'd10,  7'b1010000},
    {9'd318, 9'd10,  7'b0010000}, {9'd5,   9'd239, 7'b0000100},
    {9'd5,   9'd240, 7'b0001000}, {9'd5,   9'd244, 7'b0001000},
    {9'd5,   9'd245, 7'b0101000}, {9'd5,   9'd253, 7'b0101000},
    {9'd5,   9'd254, 7'b0001000}, {9'd340, 9'd261, 7'b0011000}
  };

  // {hide_overscan, h, v, de}, color = 0x21
  logic [19:0] os_tbl [9] = '{
    {1'b1, 9'd9,   9'd100, 1'b0}, {1'b1, 9'd10,  9'd100, 1'b1},
    {1'b1, 9'd248, 9'd100, 1'b1}, {1'b1, 9'd249, 9'd100, 1'b0},
    {1'b1, 9'd100, 9'd5,   1'b0}, {1'b1, 9'd100, 9'd6,   1'b1},
    {1'b1, 9'd100, 9'd230, 1'b1}, {1'b1, 9'd100, 9'd231, 1'b0},
    {1'b0, 9'd249, 9'd100, 1'b1}
  };

  // Returns at the negedge just after the next ce_pix has loaded the outputs.
  task automatic wait_ce();
    int n = 0;
    while (b_ce_pix !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (n >= 32) begin
      vectors++;
      errors++;
      $display("FAIL wait_ce: ce_pix got 0 want 1 within 32 cycles");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic [8:0] h, input logic [8:0] v);
    count_h = h;
    count_v = v;
    wait_ce();
  endtask

  task automatic wait_ce_n_s();
    int n = 0;
    while (s_ce_pix_n !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (n >= 32) begin
      vectors++;
      errors++;
      $display("FAIL wait_ce_n: ce_pix_n got 0 want 1 within 32 cycles");
    end
  endtask

  // Counts small-instance ce_pix_n pulses until free_run rises.
  task automatic count_to_free(output int n);
    int cyc = 0;
    n = 0;
    while (s_free_run !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (s_ce_pix_n === 1'b1) n++;
    end
    if (cyc >= 20000) n = -1;
  endtask

  // Period (rise to rise) and first high width, in clk cycles; -1 on timeout.
  task automatic rise_period(input bit sel_v, output int per, output int wid);
    logic prev, cur;
    int cyc = 0, t0 = -1;
    per = -1;
    wid = 0;
    prev = sel_v ? s_vsync : s_hsync;
    while (cyc < 20000 && per < 0) begin
      @(negedge clk);
      cyc++;
      cur = sel_v ? s_vsync : s_hsync;
      if (cur && !prev) begin
        if (t0 < 0) t0 = cyc;
        else per = cyc - t0;
      end
      if (cur && t0 >= 0 && per < 0) wid++;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({b_flags, b_ce_pix, b_ce_pix_n, b_color_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b_%b_%b_%h want all zero", b_flags, b_ce_pix,
               b_ce_pix_n, b_color_out);
    end
  endtask

  task automatic test_divider();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      vectors++;
      if ({b_ce_pix, b_ce_pix_n} !== {(k % 8 == 0), (k % 8 == 4)}) begin
        errors++;
        $display("FAIL divider cycle %0d: ce_pix/ce_pix_n got %b%b want %b%b", k, b_ce_pix,
                 b_ce_pix_n, (k % 8 == 0), (k % 8 == 4));
      end
    end
  endtask

  task automatic test_ppu_raster();
    logic [24:0] e;
    hide_overscan = 1'b0;
    color = 6'h15;
    step(9'd0, 9'd511);
    step(9'd0, 9'd0);
    for (int i = 0; i < 14; i++) begin
      e = ppu_tbl[i];
      step(e[24:16], e[15:7]);
      vectors++;
      if (b_flags !== e[6:0] || b_color_out !== (e[2] ? 6'h15 : 6'h00)) begin
        errors++;
        $display("FAIL ppu h=%0d v=%0d: flags/color got %b/%h want %b/%h", e[24:16],
                 e[15:7], b_flags, b_color_out, e[6:0], (e[2] ? 6'h15 : 6'h00));
      end
    end
  endtask

  task automatic test_overscan();
    logic [19:0] e;
    color = 6'h21;
    for (int i = 0; i < 9; i++) begin
      e = os_tbl[i];
      hide_overscan = e[19];
      step(e[18:10], e[9:1]);
      vectors++;
      if ({b_de, b_color_out} !== {e[0], (e[0] ? 6'h21 : 6'h00)}) begin
        errors++;
        $display("FAIL overscan hide=%b h=%0d v=%0d: de/color got %b/%h want %b/%h", e[19],
                 e[18:10], e[9:1], b_de, b_color_out, e[0], (e[0] ? 6'h21 : 6'h00));
      end
    end
    hide_overscan = 1'b0;
  endtask

  task automatic test_free_run_entry();
    int n, per, wid;
    step(9'd0, 9'd511);
    step(9'd0, 9'd0);
    vectors++;
    if (s_free_run !== 1'b0) begin
      errors++;
      $display("FAIL free_run_after_resync: got %b want 0", s_free_run);
    end
    count_to_free(n);
    vectors++;
    if (n !== 600) begin
      errors++;
      $display("FAIL free_run_entry: ce_pix_n count got %0d want 600", n);
    end
    rise_period(1'b0, per, wid);
    vectors++;
    if (per !== 160 || wid !== 24) begin
      errors++;
      $display("FAIL hsync_free: period/width got %0d/%0d want 160/24", per, wid);
    end
    rise_period(1'b1, per, wid);
    vectors++;
    if (per !== 1600 || wid !== 320) begin
      errors++;
      $display("FAIL vsync_ntsc: period/width got %0d/%0d want 1600/320", per, wid);
    end
  endtask

  task automatic test_resync_pal();
    int n, per, wid;
    @(negedge clk);
    pal_mode = 1'b1;
    count_h = 9'd0;
    count_v = 9'd511;
    wait_ce_n_s();
    @(negedge clk);
    count_v = 9'd0;
    wait_ce_n_s();
    vectors++;
    if (s_free_run !== 1'b1) begin
      errors++;
      $display("FAIL resync_hold: free_run got %b want 1", s_free_run);
    end
    @(negedge clk);
    vectors++;
    if (s_free_run !== 1'b0) begin
      errors++;
      $display("FAIL resync_exit: free_run got %b want 0", s_free_run);
    end
    step(9'd15, 9'd8);
    vectors++;
    if (s_flags !== 7'b1111000) begin
      errors++;
      $display("FAIL follow_ppu: flags got %b want 1111000", s_flags);
    end
    count_to_free(n);
    vectors++;
    if (n !== 840) begin
      errors++;
      $display("FAIL pal_entry: ce_pix_n count got %0d want 840", n);
    end
    rise_period(1'b1, per, wid);
    vectors++;
    if (per !== 2240 || wid !== 320) begin
      errors++;
      $display("FAIL vsync_pal: period/width got %0d/%0d want 2240/320", per, wid);
    end
  endtask

  task automatic test_async_reset();
    int n = 0, cyc = 0, m;
    while (s_hsync !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (s_hsync !== 1'b1 || s_free_run !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: hsync/free_run got %b%b want 11", s_hsync, s_free_run);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({s_flags, s_ce_pix, s_ce_pix_n, s_color_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b_%b_%b_%h want all zero", s_flags, s_ce_pix,
               s_ce_pix_n, s_color_out);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (s_ce_pix_n === 1'b1) n++;
      vectors++;
      if ({s_ce_pix, s_free_run} !== {(k == 8), 1'b0}) begin
        errors++;
        $display("FAIL reset_release cycle %0d: ce_pix/free_run got %b%b want %b0", k,
                 s_ce_pix, s_free_run, (k == 8));
      end
    end
    count_to_free(m);
    vectors++;
    if (m < 0 || n + m !== 840) begin
      errors++;
      $display("FAIL reset_relock: ce_pix_n count got %0d want 840", n + m);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_divider();
    test_ppu_raster();
    test_overscan();
    test_free_run_entry();
    test_resync_pal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
